// File: rtl/rs_alu.sv
// ALU reservation station. Holds up to RS_SIZE instructions, snoops the CDB for
// missing operands, and issues the lowest-index ready entry through a registered port.
module rs_alu #(
  parameter int               RS_SIZE = 6,
  parameter int               DATA_W  = 32,
  parameter int               TAG_W   = 4,
  parameter logic [TAG_W-1:0] NO_TAG  = 4'b1111,
  parameter logic [2:0]       NO_FREE = 3'b111
) (
  input  logic               clk,
  input  logic               rst,
  output logic [RS_SIZE-1:0] free_status,
  input  logic [2:0]         free_tag,
  input  logic               alloc_en,
  input  logic [4:0]         alloc_op,
  input  logic [TAG_W-1:0]   alloc_q1,
  input  logic [TAG_W-1:0]   alloc_q2,
  input  logic [DATA_W-1:0]  alloc_v1,
  input  logic [DATA_W-1:0]  alloc_v2,
  input  logic [TAG_W-1:0]   alloc_dest,
  input  logic               cdb_en,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_data,
  input  logic               exec_ready,
  output logic               issue_en,
  output logic [4:0]         issue_op,
  output logic [DATA_W-1:0]  issue_a,
  output logic [DATA_W-1:0]  issue_b,
  output logic [TAG_W-1:0]   issue_dest,
  input  logic               flush
);

  logic [RS_SIZE-1:0] r_valid;
  logic [4:0]         r_op   [RS_SIZE];
  logic [TAG_W-1:0]   r_q1   [RS_SIZE];
  logic [TAG_W-1:0]   r_q2   [RS_SIZE];
  logic [DATA_W-1:0]  r_v1   [RS_SIZE];
  logic [DATA_W-1:0]  r_v2   [RS_SIZE];
  logic [TAG_W-1:0]   r_dest [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_grant;
  logic               w_any;
  logic               w_issue;
  logic               w_alloc;
  logic               w_cdb_live;
  logic [4:0]         w_sel_op;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic [TAG_W-1:0]   w_sel_dest;
  logic               w_byp1;
  logic               w_byp2;
  logic [TAG_W-1:0]   w_new_q1;
  logic [TAG_W-1:0]   w_new_q2;
  logic [DATA_W-1:0]  w_new_v1;
  logic [DATA_W-1:0]  w_new_v2;

  assign free_status = ~r_valid;

  // A broadcast of NO_TAG is meaningless and must never resolve anything.
  assign w_cdb_live = cdb_en && (cdb_tag != NO_TAG);
  assign w_alloc    = alloc_en && (free_tag != NO_FREE);

  assign w_byp1   = w_cdb_live && (alloc_q1 == cdb_tag);
  assign w_byp2   = w_cdb_live && (alloc_q2 == cdb_tag);
  assign w_new_q1 = w_byp1 ? NO_TAG : alloc_q1;
  assign w_new_q2 = w_byp2 ? NO_TAG : alloc_q2;
  assign w_new_v1 = w_byp1 ? cdb_data : alloc_v1;
  assign w_new_v2 = w_byp2 ? cdb_data : alloc_v2;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_valid[i] && (r_q1[i] == NO_TAG) && (r_q2[i] == NO_TAG);
    end
  end

  // Scan from the top so the lowest ready index is the last one to win.
  always_comb begin
    w_grant    = '0;
    w_any      = 1'b0;
    w_sel_op   = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_dest = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
        w_any      = 1'b1;
        w_sel_op   = r_op[i];
        w_sel_a    = r_v1[i];
        w_sel_b    = r_v2[i];
        w_sel_dest = r_dest[i];
      end
    end
  end

  assign w_issue = exec_ready && w_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]   <= '0;
        r_q1[i]   <= NO_TAG;
        r_q2[i]   <= NO_TAG;
        r_v1[i]   <= '0;
        r_v2[i]   <= '0;
        r_dest[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_valid[i] && w_cdb_live) begin
          if (r_q1[i] == cdb_tag) begin
            r_q1[i] <= NO_TAG;
            r_v1[i] <= cdb_data;
          end
          if (r_q2[i] == cdb_tag) begin
            r_q2[i] <= NO_TAG;
            r_v2[i] <= cdb_data;
          end
        end
        if (w_issue && w_grant[i]) begin
          r_valid[i] <= 1'b0;
        end
        // The allocation target is always an empty slot, so it never collides with issue or snoop.
        if (w_alloc && (free_tag == 3'(i))) begin
          r_valid[i] <= 1'b1;
          r_op[i]    <= alloc_op;
          r_q1[i]    <= w_new_q1;
          r_q2[i]    <= w_new_q2;
          r_v1[i]    <= w_new_v1;
          r_v2[i]    <= w_new_v2;
          r_dest[i]  <= alloc_dest;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_en   <= 1'b0;
      issue_op   <= '0;
      issue_a    <= '0;
      issue_b    <= '0;
      issue_dest <= '0;
    end else if (flush) begin
      issue_en <= 1'b0;
    end else if (w_issue) begin
      issue_en   <= 1'b1;
      issue_op   <= w_sel_op;
      issue_a    <= w_sel_a;
      issue_b    <= w_sel_b;
      issue_dest <= w_sel_dest;
    end else begin
      issue_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus a randomized run
// compared against an entry-list reference model.
module tb_rs_alu;

  localparam logic [3:0] NO_TAG  = 4'hF;
  localparam logic [2:0] NO_FREE = 3'h7;

  logic        clk;
  logic        rst;
  logic [5:0]  free_status;
  logic [2:0]  free_tag;
  logic        alloc_en;
  logic [4:0]  alloc_op;
  logic [3:0]  alloc_q1, alloc_q2, alloc_dest;
  logic [31:0] alloc_v1, alloc_v2;
  logic        cdb_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        exec_ready;
  logic        issue_en;
  logic [4:0]  issue_op;
  logic [31:0] issue_a, issue_b;
  logic [3:0]  issue_dest;
  logic        flush;

  int checks = 0;
  int errors = 0;

  rs_alu dut (
    .clk(clk), .rst(rst), .free_status(free_status), .free_tag(free_tag),
    .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_q1(alloc_q1), .alloc_q2(alloc_q2),
    .alloc_v1(alloc_v1), .alloc_v2(alloc_v2), .alloc_dest(alloc_dest),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .exec_ready(exec_ready),
    .issue_en(issue_en), .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .issue_dest(issue_dest), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  dest;
  } ent_t;

  ent_t        m [6];
  logic        e_en;
  logic [4:0]  e_op;
  logic [31:0] e_a, e_b;
  logic [3:0]  e_dest;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m[i] = '0;
    e_en = 0; e_op = '0; e_a = '0; e_b = '0; e_dest = '0;
  endtask

  function automatic logic [5:0] model_fs();
    logic [5:0] fs;
    for (int i = 0; i < 6; i++) fs[i] = !m[i].valid;
    return fs;
  endfunction

  function automatic logic [2:0] model_free_tag();
    for (int i = 0; i < 6; i++) if (!m[i].valid) return 3'(i);
    return NO_FREE;
  endfunction

  // Reference behaviour of one clock edge, using the inputs currently driven.
  task automatic model_edge();
    int   sel;
    ent_t n;
    sel = -1;
    if (flush) begin
      for (int i = 0; i < 6; i++) m[i].valid = 0;
      e_en = 0;
      return;
    end
    for (int i = 0; i < 6; i++)
      if (sel < 0 && m[i].valid && m[i].q1 == NO_TAG && m[i].q2 == NO_TAG) sel = i;
    if (cdb_en && cdb_tag != NO_TAG)
      for (int i = 0; i < 6; i++)
        if (m[i].valid) begin
          if (m[i].q1 == cdb_tag) begin m[i].q1 = NO_TAG; m[i].v1 = cdb_data; end
          if (m[i].q2 == cdb_tag) begin m[i].q2 = NO_TAG; m[i].v2 = cdb_data; end
        end
    if (exec_ready && sel >= 0) begin
      e_en = 1; e_op = m[sel].op; e_a = m[sel].v1; e_b = m[sel].v2; e_dest = m[sel].dest;
      m[sel].valid = 0;
    end else begin
      e_en = 0;
    end
    if (alloc_en && free_tag != NO_FREE && free_tag < 3'd6) begin
      n.valid = 1; n.op = alloc_op; n.dest = alloc_dest;
      n.q1 = alloc_q1; n.v1 = alloc_v1; n.q2 = alloc_q2; n.v2 = alloc_v2;
      if (cdb_en && cdb_tag != NO_TAG && alloc_q1 == cdb_tag) begin n.q1 = NO_TAG; n.v1 = cdb_data; end
      if (cdb_en && cdb_tag != NO_TAG && alloc_q2 == cdb_tag) begin n.q2 = NO_TAG; n.v2 = cdb_data; end
      m[free_tag] = n;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 0; alloc_op = '0; alloc_q1 = NO_TAG; alloc_q2 = NO_TAG;
    alloc_v1 = '0; alloc_v2 = '0; alloc_dest = '0; free_tag = model_free_tag();
    cdb_en = 0; cdb_tag = NO_TAG; cdb_data = '0; flush = 0;
  endtask

  task automatic set_alloc(input logic [4:0] op, input logic [3:0] q1, input logic [3:0] q2,
                           input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] dest);
    alloc_en = 1; alloc_op = op; alloc_q1 = q1; alloc_q2 = q2;
    alloc_v1 = v1; alloc_v2 = v2; alloc_dest = dest; free_tag = model_free_tag();
  endtask

  function automatic logic [3:0] rtag();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? NO_TAG : 4'(r);
  endfunction

  task automatic test_reset();
    checks++;
    if (free_status !== 6'b111111) begin errors++; $display("FAIL reset_free_status got %b want 111111", free_status); end
    checks++;
    if (issue_en !== 1'b0 || issue_op !== 5'd0 || issue_a !== 32'd0 || issue_b !== 32'd0 || issue_dest !== 4'd0) begin
      errors++; $display("FAIL reset_issue got en=%b op=%0d a=%h b=%h dest=%0d want all 0", issue_en, issue_op, issue_a, issue_b, issue_dest);
    end
  endtask

  task automatic test_basic();
    idle(); exec_ready = 1;
    set_alloc(5'd3, NO_TAG, NO_TAG, 32'd5, 32'd7, 4'd9);
    tick();
    checks++;
    if (free_status !== 6'b111110 || issue_en !== 1'b0) begin
      errors++; $display("FAIL basic_alloc got fs=%b en=%b want fs=111110 en=0", free_status, issue_en);
    end
    idle();
    tick();
    checks++;
    if (issue_en !== 1'b1 || issue_a !== 32'd5 || issue_b !== 32'd7 || issue_op !== 5'd3 || issue_dest !== 4'd9) begin
      errors++; $display("FAIL basic_issue got en=%b a=%0d b=%0d op=%0d dest=%0d want 1 5 7 3 9", issue_en, issue_a, issue_b, issue_op, issue_dest);
    end
    checks++;
    if (free_status !== 6'b111111) begin errors++; $display("FAIL basic_freed got %b want 111111", free_status); end
  endtask

  task automatic test_snoop();
    idle(); exec_ready = 1;
    set_alloc(5'd1, 4'd3, NO_TAG, 32'd0, 32'd2, 4'd4);
    tick();
    idle(); cdb_en = 1; cdb_tag = 4'd3; cdb_data = 32'hAB;
    tick();
    checks++;
    if (issue_en !== 1'b0) begin errors++; $display("FAIL snoop_capture_no_issue got en=%b want 0", issue_en); end
    idle();
    tick();
    checks++;
    if (issue_en !== 1'b1 || issue_a !== 32'hAB || issue_b !== 32'd2) begin
      errors++; $display("FAIL snoop_issue got en=%b a=%h b=%h want 1 ab 2", issue_en, issue_a, issue_b);
    end
  endtask

  task automatic test_bypass();
    idle(); exec_ready = 1;
    set_alloc(5'd2, NO_TAG, 4'd2, 32'd1, 32'd0, 4'd6);
    cdb_en = 1; cdb_tag = 4'd2; cdb_data = 32'h11;
    tick();
    checks++;
    if (issue_en !== 1'b0 || free_status !== 6'b111110) begin
      errors++; $display("FAIL bypass_alloc got en=%b fs=%b want 0 111110", issue_en, free_status);
    end
    idle();
    tick();
    checks++;
    if (issue_en !== 1'b1 || issue_b !== 32'h11 || issue_a !== 32'd1) begin
      errors++; $display("FAIL bypass_issue got en=%b a=%h b=%h want 1 1 11", issue_en, issue_a, issue_b);
    end
  endtask

  task automatic test_full();
    idle(); exec_ready = 0;
    for (int i = 0; i < 6; i++) begin
      set_alloc(5'(i + 8), NO_TAG, NO_TAG, 32'(i * 16 + 1), 32'(i * 16 + 2), 4'(i));
      tick();
    end
    set_alloc(5'd31, NO_TAG, NO_TAG, 32'hDEAD, 32'hBEEF, 4'd14);
    free_tag = NO_FREE;
    tick();
    checks++;
    if (free_status !== 6'b000000 || issue_en !== 1'b0) begin
      errors++; $display("FAIL full_drop got fs=%b en=%b want 000000 0", free_status, issue_en);
    end
    idle(); exec_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (issue_en !== 1'b1 || issue_dest !== 4'(i) || issue_a !== 32'(i * 16 + 1)) begin
        errors++; $display("FAIL full_order_%0d got en=%b dest=%0d a=%h want 1 %0d %h", i, issue_en, issue_dest, issue_a, i, i * 16 + 1);
      end
    end
    tick();
    checks++;
    if (issue_en !== 1'b0 || free_status !== 6'b111111) begin
      errors++; $display("FAIL full_drained got en=%b fs=%b want 0 111111", issue_en, free_status);
    end
  endtask

  task automatic test_flush();
    idle(); exec_ready = 0;
    set_alloc(5'd4, NO_TAG, NO_TAG, 32'd10, 32'd11, 4'd1); tick();
    set_alloc(5'd5, 4'd5, NO_TAG, 32'd0, 32'd12, 4'd2);    tick();
    set_alloc(5'd6, NO_TAG, 4'd6, 32'd13, 32'd0, 4'd3);    tick();
    set_alloc(5'd7, NO_TAG, NO_TAG, 32'd14, 32'd15, 4'd4);
    flush = 1; exec_ready = 1;
    tick();
    checks++;
    if (free_status !== 6'b111111 || issue_en !== 1'b0) begin
      errors++; $display("FAIL flush got fs=%b en=%b want 111111 0", free_status, issue_en);
    end
    idle();
    tick();
    checks++;
    if (issue_en !== 1'b0) begin errors++; $display("FAIL flush_after got en=%b want 0", issue_en); end
  endtask

  task automatic test_async_reset();
    idle(); exec_ready = 1;
    set_alloc(5'd9, NO_TAG, NO_TAG, 32'h55, 32'h66, 4'd7);
    tick();
    set_alloc(5'd10, 4'd5, NO_TAG, 32'd0, 32'd1, 4'd8);
    tick();
    checks++;
    if (issue_en !== 1'b1 || issue_a !== 32'h55) begin
      errors++; $display("FAIL async_pre got en=%b a=%h want 1 55", issue_en, issue_a);
    end
    #3 rst = 0;
    #1;
    checks++;
    if (issue_en !== 1'b0 || free_status !== 6'b111111 || issue_a !== 32'd0) begin
      errors++; $display("FAIL async_reset got en=%b fs=%b a=%h want 0 111111 0", issue_en, free_status, issue_a);
    end
    model_reset(); idle();
    #2 rst = 1;
    tick();
    checks++;
    if (issue_en !== 1'b0 || free_status !== 6'b111111) begin
      errors++; $display("FAIL async_release got en=%b fs=%b want 0 111111", issue_en, free_status);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_op   = 5'($urandom);
      alloc_q1   = rtag();
      alloc_q2   = rtag();
      alloc_v1   = $urandom;
      alloc_v2   = $urandom;
      alloc_dest = 4'($urandom_range(0, 14));
      cdb_en     = ($urandom_range(0, 1) == 1);
      cdb_tag    = rtag();
      cdb_data   = $urandom;
      exec_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 39) == 0);
      free_tag   = ($urandom_range(0, 9) == 0) ? NO_FREE : model_free_tag();
      tick();
      checks++;
      if (issue_en !== e_en || issue_op !== e_op || issue_a !== e_a || issue_b !== e_b || issue_dest !== e_dest) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_issue c=%0d got en=%b op=%0d a=%h b=%h d=%0d want en=%b op=%0d a=%h b=%h d=%0d",
                                 c, issue_en, issue_op, issue_a, issue_b, issue_dest, e_en, e_op, e_a, e_b, e_dest);
      end
      checks++;
      if (free_status !== model_fs()) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_free c=%0d got %b want %b", c, free_status, model_fs());
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    rst = 0; exec_ready = 0;
    idle();
    #1;
    test_reset();
    #11 rst = 1;
    test_basic();
    test_snoop();
    test_bypass();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RS_SIZE, 6, number of entries
- DATA_W, 32, operand width
- TAG_W, 4, rename tag width
- NO_TAG, 4'b1111, tag meaning "operand already valid"
- NO_FREE, 3'b111, free-tag value meaning "station full"

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous, active-low reset
- free_status, out, RS_SIZE, bit i = 1 when entry i is empty
- free_tag, in, 3, lowest empty entry index from the free-tag lookup; NO_FREE when full
- alloc_en, in, 1, dispatch writes one instruction
- alloc_op, in, 5, ALU opcode
- alloc_q1, in, TAG_W, operand 1 tag
- alloc_q2, in, TAG_W, operand 2 tag
- alloc_v1, in, DATA_W, operand 1 value
- alloc_v2, in, DATA_W, operand 2 value
- alloc_dest, in, TAG_W, destination tag
- cdb_en, in, 1, result broadcast valid
- cdb_tag, in, TAG_W, broadcast tag
- cdb_data, in, DATA_W, broadcast data
- exec_ready, in, 1, ALU accepts an issue this cycle
- issue_en, out, 1, registered issue valid
- issue_op, out, 5, issued opcode
- issue_a, out, DATA_W, issued operand 1
- issue_b, out, DATA_W, issued operand 2
- issue_dest, out, TAG_W, issued destination tag
- flush, in, 1, synchronous squash of all entries

Function
REQ-003 Each entry SHALL hold valid, op, q1, v1, q2, v2 and dest; an entry is ready when valid=1 and q1=q2=NO_TAG.
REQ-004 free_status SHALL be combinational ~valid[RS_SIZE-1:0], with no dependency on same-cycle inputs.
REQ-005 When alloc_en=1 and free_tag!=NO_FREE, the entry at free_tag SHALL be written at the clock edge with valid=1.
REQ-006 When alloc_en=1 and free_tag=NO_FREE, the allocation SHALL be dropped with no state change.
REQ-007 Allocation bypass: if cdb_en=1 and alloc_qX=cdb_tag (X=1 or 2) with alloc_qX!=NO_TAG, the entry SHALL store qX=NO_TAG and vX=cdb_data.
REQ-008 Snoop: on cdb_en=1, every valid entry with qX=cdb_tag SHALL set qX=NO_TAG and vX=cdb_data at the edge; both operands may resolve in the same cycle.
REQ-009 Issue selection SHALL pick the lowest-index ready entry based on registered state only; operands captured this cycle become issuable next cycle.
REQ-010 When exec_ready=1 and a ready entry exists:
- issue_* SHALL be registered from the selected entry with issue_en=1 on the next edge
- the selected entry's valid SHALL clear on the same edge
REQ-011 Otherwise issue_en SHALL be 0 on the next edge and issue data SHALL hold its previous values.
REQ-012 Issue latency SHALL be 1 cycle from entry ready with exec_ready=1 to issue_en=1; throughput is 1 issue per cycle.
REQ-013 Allocation and issue in the same cycle SHALL both take effect; allocation targets an already-empty entry, so there is no conflict.
REQ-014 An entry freed by issue SHALL appear in free_status the cycle after issue.
REQ-015 flush=1 SHALL clear all valid bits and force issue_en=0 at the next edge, overriding same-cycle alloc and issue.
REQ-016 cdb_tag=NO_TAG SHALL never match.

Reset
REQ-017 With rst=0, asynchronously: all valid=0, free_status=6'b111111, issue_en=0, and issue_op, issue_a, issue_b, issue_dest = 0.
REQ-018 Release of rst SHALL be synchronous to clk; the first allocation is accepted on the first edge with rst=1.
REQ-019 Asserting rst mid-operation SHALL discard all entries and any pending issue.

Verification
REQ-020 Reset, then alloc tag 0 with q1=q2=NO_TAG, v1=5, v2=7, exec_ready=1 -> free_status=6'b111110 for one cycle, then issue_en=1, issue_a=5, issue_b=7, and free_status returns to 6'b111111.
REQ-021 Alloc with q1=4'd3, then cdb_en=1, cdb_tag=3, cdb_data=0xAB one cycle later -> issue the cycle after capture with issue_a=0xAB.
REQ-022 Alloc with q2=4'd2 in the same cycle as cdb_tag=2, cdb_data=0x11 -> bypass captured, issue next cycle with issue_b=0x11.
REQ-023 Fill all 6 entries with exec_ready=0, free_tag=NO_FREE, alloc_en=1 -> no state change; then raise exec_ready -> issue order is 0, 1, 2, 3, 4, 5 on consecutive cycles.
REQ-024 With 3 entries valid and one ready, assert flush together with alloc_en -> next cycle free_status=6'b111111 and issue_en=0.
REQ-025 Assert rst=0 asynchronously between edges while issue_en=1 -> issue_en drops immediately without a clock edge.
